reorder_buffer_nw: RTL and testbench
====================================

# reorder_buffer_nw

Parametrised N-wide reorder buffer for the out-of-order core, sitting between rename/dispatch and writeback. Allocates entries in program order for up to DISPATCH_W renamed instructions per cycle and accepts results from up to COMPLETE_W functional units in any order. Retires up to RETIRE_W consecutive completed entries per cycle, in order, handing back the new and old physical destinations so writeback can commit state and free registers. Successor to the fixed 2-wide ROB, with configurable depth, widths and completion ports, explicit back-pressure, and optional flush.

## Interface
- DEPTH, 16, entry count; power of two, at least 4
- DISPATCH_W, 2, dispatch slots per cycle
- COMPLETE_W, 3, completion ports
- RETIRE_W, 2, maximum retirements per cycle
- PREG_W, 6, physical register index width
- DATA_W, 32, result width
- IDX_W, $clog2(DEPTH), derived ROB tag width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- disp_valid  in  DISPATCH_W  per-slot dispatch request; set bits contiguous from bit 0
- disp_pdst  in  DISPATCH_W*PREG_W  new physical destination per slot
- disp_old_pdst  in  DISPATCH_W*PREG_W  previous mapping of the architectural destination
- disp_is_store  in  DISPATCH_W  slot is a store
- disp_ready  out  1  ROB can accept DISPATCH_W entries this cycle
- disp_tag  out  DISPATCH_W*IDX_W  tag allocated to slot i: (tail+i) mod DEPTH; combinational
- cmp_valid  in  COMPLETE_W  completion strobe per port
- cmp_tag  in  COMPLETE_W*IDX_W  ROB tag being completed
- cmp_data  in  COMPLETE_W*DATA_W  result value
- ret_valid  out  RETIRE_W  retired-slot valid, registered, contiguous from bit 0
- ret_pdst, ret_old_pdst  out  RETIRE_W*PREG_W  retired destinations
- ret_data  out  RETIRE_W*DATA_W  retired result
- ret_is_store  out  RETIRE_W  retired entry is a store
- count  out  $clog2(DEPTH+1)  occupied entries, registered
- flush  in  1  only present with ROB_FLUSH_EN

## Operation
- State: entry array (valid, done, is_store, pdst, old_pdst, data), head, tail, count.
- Dispatch: disp_ready = (DEPTH - count) >= DISPATCH_W, computed from registered count only; same-cycle retirements do not increase it. Slot i is accepted when disp_valid[i] && disp_ready. Accepted entries are written with valid=1, done=0 at tail+i, and tail advances by the number accepted. A non-contiguous disp_valid is illegal; the bench asserts on it.
- Completion: cmp_valid[p] sets done=1 and writes data at cmp_tag[p]. A completion aimed at an invalid entry is ignored. If two ports hit the same tag on the same edge, the highest port index wins.
- Completion and dispatch to the same index on the same edge cannot occur legally; dispatch wins.
- Retire: n = number of consecutive valid && done entries from head, capped at RETIRE_W, evaluated on pre-edge state. Those entries are registered onto ret_* slots 0..n-1, their valid bits are cleared, and head advances by n. ret_valid bits n and above are 0, and their data fields hold the last value.
- count_next = count + accepted - n. Pointers wrap modulo DEPTH.
- Empty (count==0): n=0. Full: disp_ready=0, while completion and retire continue.

## Timing
- Reset (async assert, sync-safe deassert): all valid/done=0; head=tail=count=0; ret_valid=0; ret_pdst/ret_old_pdst/ret_data/ret_is_store=0; disp_ready=1; disp_tag slot i = i.
- Dispatch sampled at edge k. Completion of that tag is legal from edge k+1.
- Completion sampled at edge k. The entry is retire-eligible at edge k+1, and ret_valid is visible in the cycle after edge k+1.
- Minimum dispatch-to-retire latency is 2 edges. Retire output holds for exactly one cycle per retirement.

## Configuration
- ROB_FLUSH_EN defined:
  - flush port exists.
  - flush sampled high at an edge clears all valid/done, sets head=tail=count=0 and ret_valid=0.
  - flush overrides dispatch, completion and retire on that edge.
  - Completions arriving after flush for stale tags are ignored (the target entry is invalid).
- ROB_FLUSH_EN not defined: the port is absent and the logic is removed; the ROB only drains by retirement.

## Structure
- my_package gains constants ROB_NW_DEPTH, ROB_NW_PREG_W, ROB_NW_DATA_W.
- my_package also gains the packed struct rob_nw_entry_t {valid, done, is_store, pdst, old_pdst, data}, sized from those constants. Module parameters default to them.
- One sub-module, rob_retire_select: combinational count of consecutive done entries from head, capped at RETIRE_W, producing n and per-slot indices.

## Test plan
- Reset with default parameters. Expect count=0, disp_ready=1, ret_valid=0, disp_tag={1,0}.
- Dispatch pdst 33/34 at edge 1; complete tag 1 (data 0xBEEF) at edge 2; complete tag 0 (data 0xCAFE) at edge 3. Expect ret_valid=2'b11 after edge 4, slot0 data 0xCAFE, slot1 data 0xBEEF, count back to 0.
- Dispatch 16 entries over 8 cycles with no completions. At count 15, disp_ready=0; at count 16, disp_ready=0; no overwrite. Then complete tag 0 only. Expect 1 retire, count 15, disp_ready still 0.
- Wrap: head=tail=14, dispatch 2, complete both. Expect retirement of tags 14 and 15, and the next dispatch gets tags 0/1.
- Same-edge completion of tag 5 on ports 0 and 2 with data 0x11/0x22. Expect 0x22 retired.
- ROB_FLUSH_EN with 6 entries live and a simultaneous dispatch plus flush. Expect count=0, ret_valid=0 next cycle; a later completion to old tag 3 has no effect.

Source files
------------

// File: rtl/reorder_buffer_nw_pkg.sv
// Shared constants and entry layout for the N-wide reorder buffer.
// Built with or without the ROB_FLUSH_EN flush feature.
package my_package;

    localparam int ROB_NW_DEPTH  = 16;
    localparam int ROB_NW_PREG_W = 6;
    localparam int ROB_NW_DATA_W = 32;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic                     is_store;
        logic [ROB_NW_PREG_W-1:0] pdst;
        logic [ROB_NW_PREG_W-1:0] old_pdst;
        logic [ROB_NW_DATA_W-1:0] data;
    } rob_nw_entry_t;

endpackage

// File: rtl/reorder_buffer_nw_retire_select.sv
// Counts consecutive valid+done entries starting at head, capped at RETIRE_W,
// and returns the ROB index of each candidate retire slot.
module rob_retire_select
    import my_package::*;
#(
    parameter int DEPTH    = ROB_NW_DEPTH,
    parameter int RETIRE_W = 2,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH-1:0]          done,
    input  logic [IDX_W-1:0]          head,
    output logic [CNT_W-1:0]          n,
    output logic [RETIRE_W*IDX_W-1:0] idx
);

    logic [IDX_W-1:0] slot;
    logic             stop;

    // Power-of-two depth: IDX_W-bit addition wraps the pointer for free.
    always_comb begin
        n    = '0;
        idx  = '0;
        slot = '0;
        stop = 1'b0;
        for (int i = 0; i < RETIRE_W; i++) begin
            slot = head + IDX_W'(i);
            idx[i*IDX_W +: IDX_W] = slot;
            if (!stop && valid[slot] && done[slot]) begin
                n = n + CNT_W'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_nw.sv
// N-wide reorder buffer: in-order allocate, out-of-order complete, in-order retire.
// Define ROB_FLUSH_EN to add the synchronous flush port.
module reorder_buffer_nw
    import my_package::*;
#(
    parameter int DEPTH      = ROB_NW_DEPTH,
    parameter int DISPATCH_W = 2,
    parameter int COMPLETE_W = 3,
    parameter int RETIRE_W   = 2,
    parameter int PREG_W     = ROB_NW_PREG_W,
    parameter int DATA_W     = ROB_NW_DATA_W,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef ROB_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic [DISPATCH_W-1:0]          disp_valid,
    input  logic [DISPATCH_W*PREG_W-1:0]   disp_pdst,
    input  logic [DISPATCH_W*PREG_W-1:0]   disp_old_pdst,
    input  logic [DISPATCH_W-1:0]          disp_is_store,
    output logic                           disp_ready,
    output logic [DISPATCH_W*IDX_W-1:0]    disp_tag,
    input  logic [COMPLETE_W-1:0]          cmp_valid,
    input  logic [COMPLETE_W*IDX_W-1:0]    cmp_tag,
    input  logic [COMPLETE_W*DATA_W-1:0]   cmp_data,
    output logic [RETIRE_W-1:0]            ret_valid,
    output logic [RETIRE_W*PREG_W-1:0]     ret_pdst,
    output logic [RETIRE_W*PREG_W-1:0]     ret_old_pdst,
    output logic [RETIRE_W*DATA_W-1:0]     ret_data,
    output logic [RETIRE_W-1:0]            ret_is_store,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RCNT_W = $clog2(RETIRE_W + 1);
    localparam int DCNT_W = $clog2(DISPATCH_W + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - DISPATCH_W);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              is_store;
        logic [PREG_W-1:0] pdst;
        logic [PREG_W-1:0] old_pdst;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                    ents [DEPTH];
    logic [DEPTH-1:0]          valid_vec;
    logic [DEPTH-1:0]          done_vec;
    logic [IDX_W-1:0]          head;
    logic [IDX_W-1:0]          tail;
    logic [DCNT_W-1:0]         num_acc;
    logic [RCNT_W-1:0]         ret_n;
    logic [RETIRE_W*IDX_W-1:0] ret_idx;

    // Handshake: dispatch slot i transfers on a rising edge when disp_valid[i] && disp_ready;
    // disp_ready looks only at registered count. Completion ports carry no ready and are always taken.
    assign disp_ready = (count <= READY_MAX);

    always_comb begin
        disp_tag = '0;
        num_acc  = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            disp_tag[i*IDX_W +: IDX_W] = tail + IDX_W'(i);
            if (disp_valid[i] && disp_ready) begin
                num_acc = num_acc + DCNT_W'(1);
            end
        end
    end

    always_comb begin
        valid_vec = '0;
        done_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ents[i].valid;
            done_vec[i]  = ents[i].done;
        end
    end

    rob_retire_select #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W),
        .IDX_W    (IDX_W),
        .CNT_W    (RCNT_W)
    ) u_retire_select (
        .valid (valid_vec),
        .done  (done_vec),
        .head  (head),
        .n     (ret_n),
        .idx   (ret_idx)
    );

    // Update order inside the edge: completion, then retire clears, then dispatch (dispatch wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ents[i] <= '0;
            end
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ret_valid    <= '0;
            ret_pdst     <= '0;
            ret_old_pdst <= '0;
            ret_data     <= '0;
            ret_is_store <= '0;
        end else begin
`ifdef ROB_FLUSH_EN
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ents[i].valid <= 1'b0;
                    ents[i].done  <= 1'b0;
                end
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                ret_valid <= '0;
            end else
`endif
            begin
                for (int p = 0; p < COMPLETE_W; p++) begin
                    if (cmp_valid[p] && ents[cmp_tag[p*IDX_W +: IDX_W]].valid) begin
                        ents[cmp_tag[p*IDX_W +: IDX_W]].done <= 1'b1;
                        ents[cmp_tag[p*IDX_W +: IDX_W]].data <= cmp_data[p*DATA_W +: DATA_W];
                    end
                end
                for (int i = 0; i < RETIRE_W; i++) begin
                    if (RCNT_W'(i) < ret_n) begin
                        ret_valid[i]                    <= 1'b1;
                        ret_pdst[i*PREG_W +: PREG_W]     <= ents[ret_idx[i*IDX_W +: IDX_W]].pdst;
                        ret_old_pdst[i*PREG_W +: PREG_W] <= ents[ret_idx[i*IDX_W +: IDX_W]].old_pdst;
                        ret_data[i*DATA_W +: DATA_W]     <= ents[ret_idx[i*IDX_W +: IDX_W]].data;
                        ret_is_store[i]                 <= ents[ret_idx[i*IDX_W +: IDX_W]].is_store;
                        ents[ret_idx[i*IDX_W +: IDX_W]].valid <= 1'b0;
                        ents[ret_idx[i*IDX_W +: IDX_W]].done  <= 1'b0;
                    end else begin
                        ret_valid[i] <= 1'b0;
                    end
                end
                for (int i = 0; i < DISPATCH_W; i++) begin
                    if (disp_valid[i] && disp_ready) begin
                        ents[disp_tag[i*IDX_W +: IDX_W]] <= '{
                            valid:    1'b1,
                            done:     1'b0,
                            is_store: disp_is_store[i],
                            pdst:     disp_pdst[i*PREG_W +: PREG_W],
                            old_pdst: disp_old_pdst[i*PREG_W +: PREG_W],
                            data:     '0
                        };
                    end
                end
                head  <= head + IDX_W'(ret_n);
                tail  <= tail + IDX_W'(num_acc);
                count <= count + CNT_W'(num_acc) - CNT_W'(ret_n);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_nw.sv
// Bench for reorder_buffer_nw: directed scenarios plus random traffic against a queue model.
// Flush scenarios are compiled in when ROB_FLUSH_EN is defined.
module tb_reorder_buffer_nw;
  import my_package::*;

  localparam int DEPTH = ROB_NW_DEPTH;
  localparam int DW    = 2;
  localparam int CW    = 3;
  localparam int RW    = 2;
  localparam int PW    = ROB_NW_PREG_W;
  localparam int XW    = ROB_NW_DATA_W;
  localparam int IW    = $clog2(DEPTH);
  localparam int NW    = $clog2(DEPTH + 1);
  localparam int EW    = 1 + 2 * PW + XW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush;
  logic [DW-1:0]     disp_valid;
  logic [DW*PW-1:0]  disp_pdst;
  logic [DW*PW-1:0]  disp_old_pdst;
  logic [DW-1:0]     disp_is_store;
  logic              disp_ready;
  logic [DW*IW-1:0]  disp_tag;
  logic [CW-1:0]     cmp_valid;
  logic [CW*IW-1:0]  cmp_tag;
  logic [CW*XW-1:0]  cmp_data;
  logic [RW-1:0]     ret_valid;
  logic [RW*PW-1:0]  ret_pdst;
  logic [RW*PW-1:0]  ret_old_pdst;
  logic [RW*XW-1:0]  ret_data;
  logic [RW-1:0]     ret_is_store;
  logic [NW-1:0]     count;

  // clock / reset
  always #5 clk = ~clk;

  reorder_buffer_nw #(
    .DEPTH(DEPTH), .DISPATCH_W(DW), .COMPLETE_W(CW), .RETIRE_W(RW),
    .PREG_W(PW), .DATA_W(XW)
  ) dut (
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_pdst(disp_pdst), .disp_old_pdst(disp_old_pdst),
    .disp_is_store(disp_is_store), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
    .ret_valid(ret_valid), .ret_pdst(ret_pdst), .ret_old_pdst(ret_old_pdst),
    .ret_data(ret_data), .ret_is_store(ret_is_store), .count(count)
  );

  // reference model: program-ordered queue of live entries
  typedef struct {
    int             tag;
    logic [PW-1:0]  pdst;
    logic [PW-1:0]  old_pdst;
    logic           st;
    logic           done;
    logic [XW-1:0]  data;
  } ment_t;

  ment_t          mq[$];
  int             m_head;
  int             m_n;
  logic [RW-1:0]  m_ret_valid;
  logic [RW*PW-1:0] m_ret_pdst;
  logic [RW*PW-1:0] m_ret_old;
  logic [RW*XW-1:0] m_ret_data;
  logic [RW-1:0]  m_ret_st;
  logic [EW-1:0]  exp_q[$];
  int             checks = 0;
  int             errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    disp_valid = '0;
    disp_pdst = '0;
    disp_old_pdst = '0;
    disp_is_store = '0;
    cmp_valid = '0;
    cmp_tag = '0;
    cmp_data = '0;
  endtask

  task automatic model_step();
    int n;
    int tail;
    bit ready;
    ment_t e;
    if (flush) begin
      mq.delete();
      m_head = 0;
      m_n = 0;
      m_ret_valid = '0;
      return;
    end
    ready = (mq.size() + DW <= DEPTH);
    n = 0;
    while (n < RW && n < mq.size() && mq[n].done) n++;
    m_ret_valid = '0;
    for (int i = 0; i < n; i++) begin
      e = mq[i];
      m_ret_valid[i] = 1'b1;
      m_ret_pdst[i*PW +: PW] = e.pdst;
      m_ret_old[i*PW +: PW] = e.old_pdst;
      m_ret_data[i*XW +: XW] = e.data;
      m_ret_st[i] = e.st;
      exp_q.push_back({e.st, e.pdst, e.old_pdst, e.data});
    end
    for (int p = 0; p < CW; p++) begin
      if (cmp_valid[p]) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].tag == int'(cmp_tag[p*IW +: IW])) begin
            e = mq[j];
            e.done = 1'b1;
            e.data = cmp_data[p*XW +: XW];
            mq[j] = e;
          end
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      mq.delete(0);
      m_head = (m_head + 1) % DEPTH;
    end
    m_n = n;
    tail = (m_head + mq.size()) % DEPTH;
    if (ready) begin
      for (int i = 0; i < DW; i++) begin
        if (disp_valid[i]) begin
          e.tag = (tail + i) % DEPTH;
          e.pdst = disp_pdst[i*PW +: PW];
          e.old_pdst = disp_old_pdst[i*PW +: PW];
          e.st = disp_is_store[i];
          e.done = 1'b0;
          e.data = '0;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [DW*IW-1:0] etag;
    logic [EW-1:0] got;
    for (int i = 0; i < DW; i++) etag[i*IW +: IW] = IW'((m_head + mq.size() + i) % DEPTH);
    check("count", count, mq.size());
    check("disp_ready", disp_ready, (mq.size() + DW <= DEPTH));
    check("disp_tag", disp_tag, etag);
    check("ret_valid", ret_valid, m_ret_valid);
    check("ret_pdst", ret_pdst, m_ret_pdst);
    check("ret_old_pdst", ret_old_pdst, m_ret_old);
    check("ret_data", ret_data, m_ret_data);
    check("ret_is_store", ret_is_store, m_ret_st);
    for (int i = 0; i < m_n; i++) begin
      got = {ret_is_store[i], ret_pdst[i*PW +: PW], ret_old_pdst[i*PW +: PW], ret_data[i*XW +: XW]};
      if (exp_q.size() > 0) check("ret_entry", got, exp_q.pop_front());
    end
  endtask

  // driver: caller sets inputs, tick applies one edge and checks afterwards
  task automatic tick();
    logic [DW-1:0] inc;
    inc = disp_valid + 1'b1;
    assert ((disp_valid & inc) == '0) else $error("illegal non-contiguous disp_valid %b", disp_valid);
    model_step();
    @(posedge clk);
    #1;
    clear_inputs();
    compare_outputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    m_head = 0;
    m_n = 0;
    m_ret_valid = '0;
    m_ret_pdst = '0;
    m_ret_old = '0;
    m_ret_data = '0;
    m_ret_st = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_outputs();
  endtask

  task automatic dispatch2(input logic [PW-1:0] p0, input logic [PW-1:0] p1);
    disp_valid = 2'b11;
    disp_pdst = {p1, p0};
    disp_old_pdst = {PW'(p1 + 1), PW'(p0 + 1)};
    disp_is_store = 2'b10;
  endtask

  task automatic complete(input int port, input int tag, input logic [XW-1:0] data);
    cmp_valid[port] = 1'b1;
    cmp_tag[port*IW +: IW] = IW'(tag);
    cmp_data[port*XW +: XW] = data;
  endtask

  initial begin
    int k;
    clear_inputs();

    // reset values
    do_reset();
    check("rst_count", count, 0);
    check("rst_ready", disp_ready, 1);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_disp_tag", disp_tag, 8'h10);

    // two dispatched, completed out of order, retired together
    dispatch2(6'd33, 6'd34); tick();
    complete(0, 1, 32'hBEEF); tick();
    complete(0, 0, 32'hCAFE); tick();
    tick();
    check("pair_ret_valid", ret_valid, 2'b11);
    check("pair_data0", ret_data[31:0], 32'hCAFE);
    check("pair_data1", ret_data[63:32], 32'hBEEF);
    check("pair_pdst", ret_pdst, {6'd34, 6'd33});
    check("pair_count", count, 0);

    // fill to full, then one retirement
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dispatch2(PW'(2 * i), PW'(2 * i + 1)); tick();
    end
    check("full_count", count, 16);
    check("full_ready", disp_ready, 0);
    dispatch2(6'd60, 6'd61); tick();
    check("full_no_overwrite", count, 16);
    complete(0, 0, 32'h1234); tick();
    tick();
    check("full_ret_valid", ret_valid, 2'b01);
    check("full_ret_pdst", ret_pdst[PW-1:0], 0);
    check("full_count15", count, 15);
    check("full_ready15", disp_ready, 0);

    // pointer wrap at 14/15
    do_reset();
    for (int i = 0; i < 7; i++) begin
      dispatch2(PW'(i), PW'(i + 8)); tick();
      complete(0, 2 * i, XW'(i)); complete(1, 2 * i + 1, XW'(i + 100)); tick();
      tick();
    end
    check("wrap_tag_pre", disp_tag, 8'hFE);
    dispatch2(6'd20, 6'd21); tick();
    complete(2, 15, 32'hF15); complete(1, 14, 32'hE14); tick();
    tick();
    check("wrap_ret_valid", ret_valid, 2'b11);
    check("wrap_ret_data", ret_data, {32'hF15, 32'hE14});
    check("wrap_tag_post", disp_tag, 8'h10);

    // same-edge completion of one tag on two ports
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dispatch2(PW'(2 * i), PW'(2 * i + 1)); tick();
    end
    complete(0, 0, 32'h0); complete(1, 1, 32'h1); complete(2, 2, 32'h2); tick();
    complete(0, 3, 32'h3); complete(1, 4, 32'h4); tick();
    tick();
    tick();
    check("dup_count", count, 1);
    complete(0, 5, 32'h11); complete(2, 5, 32'h22); tick();
    tick();
    check("dup_ret_valid", ret_valid, 2'b01);
    check("dup_ret_data", ret_data[XW-1:0], 32'h22);

`ifdef ROB_FLUSH_EN
    // flush with live entries and a concurrent dispatch
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dispatch2(PW'(2 * i), PW'(2 * i + 1)); tick();
    end
    dispatch2(6'd40, 6'd41);
    flush = 1'b1;
    tick();
    check("flush_count", count, 0);
    check("flush_ret_valid", ret_valid, 0);
    complete(0, 3, 32'hDEAD); tick();
    tick();
    check("flush_stale_count", count, 0);
    check("flush_stale_ret", ret_valid, 0);
`endif

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, DW);
      disp_valid = DW'((1 << k) - 1);
      for (int i = 0; i < DW; i++) begin
        disp_pdst[i*PW +: PW] = PW'($urandom);
        disp_old_pdst[i*PW +: PW] = PW'($urandom);
        disp_is_store[i] = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < CW; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            complete(p, mq[$urandom_range(0, mq.size() - 1)].tag, $urandom);
          else
            complete(p, $urandom_range(0, DEPTH - 1), $urandom);
        end
      end
`ifdef ROB_FLUSH_EN
      flush = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
